// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush controller for load-use, taken-branch squash and memory wait
module hazard_stall_unit #(
  parameter int LOAD_STALLS  = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_reg_write,
  input  logic             branch_taken,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             id_ex_bubble,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);
  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH} state_t;
  localparam logic [2:0] LS_REM = 3'(LOAD_STALLS - 1);
  localparam logic [2:0] FC_REM = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = 1;
  state_t state_q, state_d;
  logic [2:0] rem_q, rem_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic load_use, br_acc, stall, flush;
  assign load_use = ex_mem_read & ex_reg_write & (ex_rd != 5'd0)
                  & ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
  // a branch only counts when the pipeline is not frozen; the source holds it otherwise
  assign br_acc = branch_taken & ~mem_busy;
  // state, remaining-count and counter registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= RUN;
      rem_q   <= 3'd0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  // next state: freeze holds, branch aborts any stall, then continuation, then new load-use
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (mem_busy) begin
      state_d = state_q;
    end else if (branch_taken) begin
      state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
      rem_d   = FLUSH_CYCLES > 1 ? FC_REM : 3'd0;
    end else if (state_q != RUN) begin
      state_d = rem_q == 3'd1 ? RUN : state_q;
      rem_d   = rem_q - 3'd1;
    end else if (load_use && LOAD_STALLS > 1) begin
      state_d = LU_STALL;
      rem_d   = LS_REM;
    end
  end
  // outputs: all enables low while reset is asserted
  always_comb begin
    stall          = ~mem_busy & ~branch_taken & ((state_q == LU_STALL) | ((state_q == RUN) & load_use));
    flush          = ~mem_busy & (branch_taken | (state_q == FLUSH));
    pc_write_en    = arst_n & ~mem_busy & ~stall;
    if_id_write_en = arst_n & ~mem_busy & ~stall;
    id_ex_bubble   = arst_n & stall;
    if_id_flush    = arst_n & flush;
    id_ex_flush    = arst_n & flush;
    pipe_freeze    = arst_n & mem_busy;
  end
  // saturating performance counters, clear wins over increment
  always_comb begin
    stall_d = perf_clr ? '0 : (id_ex_bubble && stall_q != '1) ? stall_q + ONE : stall_q;
    flush_d = perf_clr ? '0 : (br_acc && flush_q != '1) ? flush_q + ONE : flush_q;
  end
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: table-driven and sequence checks of the stall/flush controller
module tb_hazard_stall_unit;
  logic clk = 0, arst_n = 0;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write, branch_taken, mem_busy, perf_clr;
  logic a_pc, a_ifid, a_bub, a_iff, a_idf, a_frz;
  logic b_pc, b_ifid, b_bub, b_iff, b_idf, b_frz;
  logic [15:0] a_stall, a_flush;
  logic [3:0] b_stall, b_flush;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  hazard_stall_unit #(.LOAD_STALLS(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .arst_n(arst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .perf_clr(perf_clr),
    .pc_write_en(a_pc), .if_id_write_en(a_ifid), .id_ex_bubble(a_bub), .if_id_flush(a_iff),
    .id_ex_flush(a_idf), .pipe_freeze(a_frz), .stall_cycles(a_stall), .flush_events(a_flush));
  hazard_stall_unit #(.LOAD_STALLS(3), .FLUSH_CYCLES(3), .CNT_W(4)) dut_b (
    .clk(clk), .arst_n(arst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .branch_taken(branch_taken), .mem_busy(mem_busy), .perf_clr(perf_clr),
    .pc_write_en(b_pc), .if_id_write_en(b_ifid), .id_ex_bubble(b_bub), .if_id_flush(b_iff),
    .id_ex_flush(b_idf), .pipe_freeze(b_frz), .stall_cycles(b_stall), .flush_events(b_flush));
  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mr, rw, bt, mb;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[13];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passed++;
  endtask
  task automatic drive(input logic [4:0] rs1, rs2, rd, input logic u1, u2, mr, rw, bt, mb);
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_mem_read = mr; ex_reg_write = rw; branch_taken = bt; mem_busy = mb;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic lu();
    drive(5, 0, 5, 1, 0, 1, 1, 0, 0);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_rst();
    arst_n = 0;
    #1;
    arst_n = 1;
    #1;
  endtask
  function automatic logic [5:0] bo();
    return {b_pc, b_ifid, b_bub, b_iff, b_idf, b_frz};
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [15:0] es, ef;
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b110000};
    vecs[1]  = '{5, 0, 5, 1, 0, 1, 1, 0, 0, 6'b001000};
    vecs[2]  = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 6'b110000};
    vecs[3]  = '{5, 0, 5, 0, 0, 1, 1, 0, 0, 6'b110000};
    vecs[4]  = '{1, 7, 7, 0, 1, 1, 1, 0, 0, 6'b001000};
    vecs[5]  = '{1, 7, 7, 0, 1, 0, 1, 0, 0, 6'b110000};
    vecs[6]  = '{1, 7, 7, 0, 1, 1, 0, 0, 0, 6'b110000};
    vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 6'b110110};
    vecs[8]  = '{5, 0, 5, 1, 0, 1, 1, 1, 0, 6'b110110};
    vecs[9]  = '{5, 0, 5, 1, 0, 1, 1, 0, 1, 6'b000001};
    vecs[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b000001};
    vecs[11] = '{3, 5, 5, 1, 0, 1, 1, 0, 0, 6'b110000};
    vecs[12] = '{9, 9, 9, 1, 1, 1, 1, 0, 0, 6'b001000};
    perf_clr = 0;
    idle();
    #3;
    chk("reset_a_out", {a_pc, a_ifid, a_bub, a_iff, a_idf, a_frz}, 6'b000000);
    chk("reset_b_out", bo(), 6'b000000);
    chk("reset_cnt", {a_stall, a_flush, b_stall, b_flush}, 0);
    arst_n = 1;
    tick();
    es = 0;
    ef = 0;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2,
            vecs[i].mr, vecs[i].rw, vecs[i].bt, vecs[i].mb);
      #2;
      chk($sformatf("vec%0d_out", i), {a_pc, a_ifid, a_bub, a_iff, a_idf, a_frz}, vecs[i].exp);
      chk($sformatf("vec%0d_stall_cnt", i), a_stall, es);
      chk($sformatf("vec%0d_flush_cnt", i), a_flush, ef);
      es += 16'(vecs[i].exp[3]);
      ef += 16'(vecs[i].bt & ~vecs[i].mb);
      tick();
    end
    chk("tbl_stall_final", a_stall, es);
    chk("tbl_flush_final", a_flush, ef);
    // three-cycle load-use stall; load_use is dropped after the first cycle
    idle();
    pulse_rst();
    lu();
    #1;
    chk("ls3_c1", bo(), 6'b001000);
    tick();
    idle();
    #1;
    chk("ls3_c2", bo(), 6'b001000);
    tick();
    #1;
    chk("ls3_c3", bo(), 6'b001000);
    tick();
    #1;
    chk("ls3_run", bo(), 6'b110000);
    chk("ls3_cnt", b_stall, 3);
    // branch in second stall cycle aborts the stall, then a 3-cycle flush
    pulse_rst();
    lu();
    #1;
    chk("br_c1", bo(), 6'b001000);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1;
    chk("br_c2", bo(), 6'b110110);
    tick();
    idle();
    #1;
    chk("br_fl2", bo(), 6'b110110);
    tick();
    #1;
    chk("br_fl3", bo(), 6'b110110);
    tick();
    #1;
    chk("br_run", bo(), 6'b110000);
    chk("br_cnt", {b_stall, b_flush}, 8'h11);
    // memory wait mid-stall holds state, then the two remaining bubbles
    pulse_rst();
    lu();
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, i == 1, 1);
      #1;
      chk($sformatf("mb_c%0d", i), bo(), 6'b000001);
      tick();
    end
    idle();
    #1;
    chk("mb_after1", bo(), 6'b001000);
    chk("mb_cnt_held", {b_stall, b_flush}, 8'h10);
    tick();
    #1;
    chk("mb_after2", bo(), 6'b001000);
    tick();
    #1;
    chk("mb_run", bo(), 6'b110000);
    chk("mb_cnt", {b_stall, b_flush}, 8'h30);
    // counter saturation and clear
    pulse_rst();
    lu();
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", b_stall, 15);
    perf_clr = 1;
    tick();
    perf_clr = 0;
    chk("clr_stall", b_stall, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_flush", b_flush, 15);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    perf_clr = 1;
    tick();
    perf_clr = 0;
    chk("clr_busy", {b_stall, b_flush}, 8'h00);
    // asynchronous reset in the middle of a flush
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    idle();
    #1;
    chk("pre_rst_flush", bo(), 6'b110110);
    arst_n = 0;
    #1;
    chk("rst_mid_out", bo(), 6'b000000);
    chk("rst_mid_cnt", {b_stall, b_flush}, 8'h00);
    arst_n = 1;
    #1;
    chk("rst_mid_run", bo(), 6'b110000);
    tick();
    #1;
    chk("rst_mid_run2", bo(), 6'b110000);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
